// File: rtl/spi_ram_ctrl.sv
// Command sequencer between an SPI slave's parallel frame interface and a
// single-port synchronous RAM: address loads, burst writes/reads, read-data return.
module spi_ram_ctrl #(
  parameter int ADDR_SIZE = 8,
  parameter int MEM_DEPTH = 256,
  parameter int TX_CYCLES = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [9:0]           rx_data,
  input  logic                 rx_valid,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [7:0]           mem_wdata,
  output logic                 mem_we,
  output logic                 mem_re,
  input  logic [7:0]           mem_rdata,
  output logic                 seq_err
);

  localparam int CNT_W = $clog2(TX_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_MEM,
    S_RD_MEM,
    S_RD_WAIT,
    S_TX_HOLD
  } state_e;

  state_e               state_q;
  logic                 rx_valid_prev_q;
  logic [ADDR_SIZE-1:0] wr_ptr_q, rd_ptr_q;
  logic                 wr_ok_q, rd_ok_q;
  logic [CNT_W-1:0]     hold_cnt_q;
  logic [7:0]           tx_data_q;
  logic                 tx_valid_q;
  logic [ADDR_SIZE-1:0] mem_addr_q;
  logic [7:0]           mem_wdata_q;
  logic                 mem_we_q, mem_re_q;
  logic                 seq_err_q;

  logic                 new_frame;
  logic [1:0]           opcode;
  logic [7:0]           payload;
  logic                 payload_in_range;
  logic [ADDR_SIZE-1:0] payload_addr;

  // A frame is the rising edge of rx_valid; a held level never re-triggers.
  assign new_frame        = rx_valid & ~rx_valid_prev_q;
  assign opcode           = rx_data[9:8];
  assign payload          = rx_data[7:0];
  assign payload_in_range = {24'd0, payload} < 32'(MEM_DEPTH);
  assign payload_addr     = ADDR_SIZE'(payload);

  function automatic logic [ADDR_SIZE-1:0] ptr_inc(input logic [ADDR_SIZE-1:0] p);
    return (p == ADDR_SIZE'(MEM_DEPTH - 1)) ? '0 : p + ADDR_SIZE'(1);
  endfunction

  // NOTE: sequential state uses non-blocking assignments only, so every
  // branch below reads the pre-edge value of every register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      rx_valid_prev_q <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      wr_ok_q         <= 1'b0;
      rd_ok_q         <= 1'b0;
      hold_cnt_q      <= '0;
      tx_data_q       <= '0;
      tx_valid_q      <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      mem_we_q        <= 1'b0;
      mem_re_q        <= 1'b0;
      seq_err_q       <= 1'b0;
    end else begin
      rx_valid_prev_q <= rx_valid;
      seq_err_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (new_frame) begin
            case (opcode)
              2'b00: begin
                if (payload_in_range) begin
                  wr_ptr_q <= payload_addr;
                  wr_ok_q  <= 1'b1;
                end else begin
                  seq_err_q <= 1'b1;
                end
              end
              2'b01: begin
                if (wr_ok_q) begin
                  state_q     <= S_WR_MEM;
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= wr_ptr_q;
                  mem_wdata_q <= payload;
                end else begin
                  seq_err_q <= 1'b1;
                end
              end
              2'b10: begin
                if (payload_in_range) begin
                  rd_ptr_q <= payload_addr;
                  rd_ok_q  <= 1'b1;
                end else begin
                  seq_err_q <= 1'b1;
                end
              end
              2'b11: begin
                if (rd_ok_q) begin
                  state_q    <= S_RD_MEM;
                  mem_re_q   <= 1'b1;
                  mem_addr_q <= rd_ptr_q;
                end else begin
                  seq_err_q <= 1'b1;
                end
              end
            endcase
          end
        end
        S_WR_MEM: begin
          mem_we_q <= 1'b0;
          wr_ptr_q <= ptr_inc(wr_ptr_q);
          state_q  <= S_IDLE;
        end
        S_RD_MEM: begin
          mem_re_q <= 1'b0;
          state_q  <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          tx_data_q  <= mem_rdata;
          tx_valid_q <= 1'b1;
          rd_ptr_q   <= ptr_inc(rd_ptr_q);
          hold_cnt_q <= CNT_W'(TX_CYCLES - 1);
          state_q    <= S_TX_HOLD;
        end
        S_TX_HOLD: begin
          // The rising cycle counts as the first of the TX_CYCLES held cycles.
          if (hold_cnt_q == '0) begin
            tx_valid_q <= 1'b0;
            state_q    <= S_IDLE;
          end else begin
            hold_cnt_q <= hold_cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (new_frame && (state_q != S_IDLE)) seq_err_q <= 1'b1;
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign seq_err   = seq_err_q;

endmodule

// File: doc/spi_ram_ctrl.md
Name: spi_ram_ctrl

Overview:
Command sequencer between the SPI slave's parallel side and a single-port synchronous RAM. Decodes each 10-bit frame from the slave (rx_data[9:8] = opcode, rx_data[7:0] = payload) into address loads, RAM writes and RAM reads. Returns read data to the slave via tx_data/tx_valid, held for one full 8-bit shift-out window. Auto-increments write and read pointers for burst access and flags illegal command sequences.

Parameters:
ADDR_SIZE, 8, RAM address width.
MEM_DEPTH, 256, number of valid RAM locations (≤ 2^ADDR_SIZE).
TX_CYCLES, 9, clocks tx_valid is held after read data is presented.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst  in  1  synchronous reset, active-high.
rx_data  in  10  frame from SPI slave; [9:8] opcode, [7:0] payload.
rx_valid  in  1  frame valid; level, may stay high several cycles.
tx_data  out  8  read data to SPI slave.
tx_valid  out  1  tx_data valid; held TX_CYCLES clocks.
mem_addr  out  ADDR_SIZE  RAM address.
mem_wdata  out  8  RAM write data.
mem_we  out  1  RAM write strobe, one cycle per write.
mem_re  out  1  RAM read strobe, one cycle per read.
mem_rdata  in  8  RAM read data, valid the cycle after mem_re.
seq_err  out  1  one-cycle pulse on illegal/dropped command.

Behaviour:
- Reset: all outputs 0; wr_ptr=rd_ptr=0; wr_ok=rd_ok=0; rx_valid_d=0; state IDLE. Reset wins over every other event, including mid-read or during TX_HOLD (tx_valid low after that edge).
- Frame accept: "new frame" = rx_valid & ~rx_valid_d (rx_valid_d registered every cycle). Level-high rx_valid never re-triggers.
- States: IDLE, WR_MEM, RD_MEM, RD_WAIT, TX_HOLD. New frame acted on only in IDLE; a new frame in any other state is dropped, seq_err pulses, state unaffected.
- Opcode 00 (write address): payload < MEM_DEPTH -> wr_ptr=payload, wr_ok=1; else seq_err, wr_ok unchanged. Stay IDLE.
- Opcode 01 (write data): wr_ok=1 -> IDLE->WR_MEM; during WR_MEM mem_we=1, mem_addr=wr_ptr, mem_wdata=payload (captured at accept); on leaving WR_MEM wr_ptr increments, MEM_DEPTH-1 wraps to 0; back to IDLE. wr_ok=0 -> seq_err, no write.
- Opcode 10 (read address): same as 00 but targets rd_ptr/rd_ok.
- Opcode 11 (read data): rd_ok=1 -> RD_MEM (mem_re=1, mem_addr=rd_ptr, one cycle) -> RD_WAIT (mem_rdata valid; tx_data<=mem_rdata, tx_valid<=1 at end of cycle, rd_ptr increments with wrap) -> TX_HOLD for TX_CYCLES cycles counting from tx_valid rise -> tx_valid<=0, IDLE. rd_ok=0 -> seq_err, no read.
- Latency (edge E0 samples new frame): write mem_we high E0..E1; read mem_re high E0..E1, tx_valid high E2..E2+TX_CYCLES.
- mem_we and mem_re never high together; both 0 outside WR_MEM/RD_MEM; mem_addr/mem_wdata hold last value otherwise.
- tx_data holds last read value after tx_valid drops until next read.
- wr_ok/rd_ok stay set until reset; pointers persist across frames.

Test Plan:
- Reset then opcode 11 frame -> seq_err one pulse, mem_re never asserted, tx_valid stays 0.
- Frame 0x005 then 0x1A5 -> one mem_we pulse with mem_addr=0x05, mem_wdata=0xA5; second frame 0x13C -> write at 0x06 (auto-increment).
- RAM preloaded [0x10]=0x77: frames 0x210, 0x3xx -> mem_re at addr 0x10, tx_data=0x77, tx_valid high exactly 9 clocks starting 2 clocks after accept.
- Pointer wrap: MEM_DEPTH=256, write addr 0xFF, two data writes -> addresses 0xFF then 0x00; with MEM_DEPTH=200, frame 0x0C8 -> seq_err, wr_ok stays 0.
- rx_valid held high 12 cycles on one frame -> exactly one action; new frame arriving during TX_HOLD -> seq_err pulse, tx_valid unaffected.
- rst asserted mid TX_HOLD -> tx_valid 0 next cycle, rd_ok cleared, subsequent opcode 11 -> seq_err.
